// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and read-router FSM state encoding
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} rd_state_e;
endpackage

// File: rtl/axi_addr_decoder.sv
// axi_addr_decoder: fixed map addr -> one-hot target (port0 <0x1000_0000, port1 <0x4000_0000, port2 otherwise); misroute when no bit survives AXI_PORT_NUM
module axi_addr_decoder
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_PORT_NUM   = 3
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [AXI_PORT_NUM-1:0]   target,
  output logic                      misroute
);
  logic lo, mid, hi;
  assign lo  = addr < AXI_ADDR_WIDTH'(32'h1000_0000);
  assign mid = !lo && addr < AXI_ADDR_WIDTH'(32'h4000_0000);
  assign hi  = !lo && !mid;
  always_comb begin
    target = '0;
    for (int k = 0; k < AXI_PORT_NUM; k++)
      target[k] = k == 0 ? lo : k == 1 ? mid : k == 2 ? hi : 1'b0;
  end
  assign misroute = target == '0;
endmodule

// File: rtl/axi_lite_rd_router.sv
// axi_lite_rd_router: single-outstanding AXI4-Lite read router (s_* master side, m_* one-hot slave ports, DECERR for unmapped; err_cnt_o with AXI_RD_ROUTER_ERR_CNT_EN)
module axi_lite_rd_router
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_PORT_NUM   = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0]              s_araddr_i,
  input  logic                                   s_arvalid_i,
  output logic                                   s_arready_o,
  output logic [AXI_DATA_WIDTH-1:0]              s_rdata_o,
  output logic [1:0]                             s_rresp_o,
  output logic                                   s_rvalid_o,
  input  logic                                   s_rready_i,
  output logic [AXI_ADDR_WIDTH-1:0]              m_araddr_o,
  output logic [AXI_PORT_NUM-1:0]                m_arvalid_o,
  input  logic [AXI_PORT_NUM-1:0]                m_arready_i,
  input  logic [AXI_PORT_NUM*AXI_DATA_WIDTH-1:0] m_rdata_i,
  input  logic [2*AXI_PORT_NUM-1:0]              m_rresp_i,
  input  logic [AXI_PORT_NUM-1:0]                m_rvalid_i,
  output logic [AXI_PORT_NUM-1:0]                m_rready_o
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
  ,output logic [15:0]                           err_cnt_o
`endif
);
  rd_state_e state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_PORT_NUM-1:0] sel_q, dec_sel;
  logic dec_err, ar_hs, ar_done, r_done;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, mux_data;
  logic [1:0] rresp_q, mux_resp;
  axi_addr_decoder #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_PORT_NUM(AXI_PORT_NUM)) u_dec (
    .addr(s_araddr_i), .target(dec_sel), .misroute(dec_err)
  );
  assign ar_hs   = state_q == IDLE && s_arvalid_i;
  assign ar_done = state_q == ADDR && |(m_arready_i & sel_q);
  assign r_done  = state_q == DATA && |(m_rvalid_i & sel_q);
  always_comb begin
    mux_data = '0;
    mux_resp = '0;
    for (int k = 0; k < AXI_PORT_NUM; k++) begin
      mux_data |= m_rdata_i[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] & {AXI_DATA_WIDTH{sel_q[k]}};
      mux_resp |= m_rresp_i[k*2 +: 2] & {2{sel_q[k]}};
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = s_arvalid_i ? (dec_err ? RESP : ADDR) : IDLE;
      ADDR:    state_d = ar_done ? DATA : ADDR;
      DATA:    state_d = r_done ? RESP : DATA;
      default: state_d = s_rready_i ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      addr_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      addr_q <= s_araddr_i;
      sel_q  <= dec_sel;
      if (dec_err) begin
        rdata_q <= '0;
        rresp_q <= RESP_DECERR;
      end
    end else if (r_done) begin
      rdata_q <= mux_data;
      rresp_q <= mux_resp;
    end
  assign s_arready_o = state_q == IDLE;
  assign s_rvalid_o  = state_q == RESP;
  assign s_rdata_o   = rdata_q;
  assign s_rresp_o   = rresp_q;
  assign m_araddr_o  = addr_q;
  assign m_arvalid_o = state_q == ADDR ? sel_q : '0;
  assign m_rready_o  = state_q == DATA ? sel_q : '0;
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_cnt_o <= '0;
    else if (ar_hs && dec_err && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
`endif
endmodule

// File: tb/tb_axi_lite_rd_router.sv
// tb_axi_lite_rd_router: directed + randomized checks of the read router (3-port and 2-port instances)
module tb_axi_lite_rd_router;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [31:0] s_araddr = 0, s_rdata, m_araddr;
  logic s_arvalid = 0, s_arready, s_rvalid, s_rready = 0;
  logic [1:0] s_rresp;
  logic [2:0] m_arvalid, m_arready = 0, m_rvalid = 0, m_rready;
  logic [95:0] m_rdata = 0;
  logic [5:0] m_rresp = 0;
  logic [31:0] s_araddr2 = 0, s_rdata2, m_araddr2;
  logic s_arvalid2 = 0, s_arready2, s_rvalid2, s_rready2 = 0;
  logic [1:0] s_rresp2;
  logic [1:0] m_arvalid2, m_rready2;
  logic [63:0] m_rdata2 = 0;
  logic [3:0] m_rresp2 = 0;
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
  logic [15:0] err_cnt, err_cnt2;
  int decerr_n = 0;
`endif
  axi_lite_rd_router #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_PORT_NUM(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .s_araddr_i(s_araddr), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
    .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_rdata_i(m_rdata),
    .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready)
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );
  axi_lite_rd_router #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_PORT_NUM(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .s_araddr_i(s_araddr2), .s_arvalid_i(s_arvalid2), .s_arready_o(s_arready2),
    .s_rdata_o(s_rdata2), .s_rresp_o(s_rresp2), .s_rvalid_o(s_rvalid2), .s_rready_i(s_rready2),
    .m_araddr_o(m_araddr2), .m_arvalid_o(m_arvalid2), .m_arready_i(2'b11), .m_rdata_i(m_rdata2),
    .m_rresp_i(m_rresp2), .m_rvalid_i(2'b11), .m_rready_o(m_rready2)
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
    , .err_cnt_o(err_cnt2)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int port_of(input logic [31:0] a);
    return a < 32'h1000_0000 ? 0 : a < 32'h4000_0000 ? 1 : 2;
  endfunction
  task automatic chk_reset();
    chk("rst_arready", s_arready, 1);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_rresp", s_rresp, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst2_arready", s_arready2, 1);
    chk("rst2_rvalid", s_rvalid2, 0);
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
    chk("rst_errcnt", err_cnt, 0);
    chk("rst2_errcnt", err_cnt2, 0);
`endif
  endtask
  task automatic read3(input logic [31:0] addr, input int arw, input int rw, input int rdw,
                       input logic [31:0] data, input logic [1:0] resp);
    int p;
    logic [2:0] oh;
    p = port_of(addr);
    oh = 3'b001 << p;
    @(negedge clk);
    chk("arready_idle", s_arready, 1);
    s_araddr = addr;
    s_arvalid = 1;
    @(negedge clk);
    s_arvalid = 0;
    s_araddr = $urandom;
    chk("arvalid_t1", m_arvalid, oh);
    chk("araddr_t1", m_araddr, addr);
    chk("arready_busy", s_arready, 0);
    for (int i = 0; i < arw; i++) begin
      m_arready = 3'($urandom) & ~oh;
      @(negedge clk);
      chk("arvalid_hold", m_arvalid, oh);
      chk("araddr_hold", m_araddr, addr);
    end
    m_arready = oh | (3'($urandom) & ~oh);
    @(negedge clk);
    m_arready = 0;
    chk("arvalid_drop", m_arvalid, 0);
    chk("rready_data", m_rready, oh);
    for (int i = 0; i < rw; i++) begin
      m_rvalid = 3'($urandom) & ~oh;
      m_rdata = {$urandom, $urandom, $urandom};
      m_rresp = 6'($urandom);
      @(negedge clk);
      chk("rready_hold", m_rready, oh);
      chk("rvalid_early", s_rvalid, 0);
    end
    m_rvalid = oh | (3'($urandom) & ~oh);
    m_rdata = {$urandom, $urandom, $urandom};
    m_rresp = 6'($urandom);
    m_rdata[p*32 +: 32] = data;
    m_rresp[p*2 +: 2] = resp;
    @(negedge clk);
    m_rvalid = 0;
    m_rdata = {$urandom, $urandom, $urandom};
    chk("rvalid_resp", s_rvalid, 1);
    chk("rdata", s_rdata, data);
    chk("rresp", s_rresp, resp);
    chk("rready_drop", m_rready, 0);
    chk("arready_resp", s_arready, 0);
    for (int i = 0; i < rdw; i++) begin
      s_rready = 0;
      s_arvalid = 1;
      s_araddr = $urandom;
      @(negedge clk);
      chk("rvalid_stall", s_rvalid, 1);
      chk("rdata_stall", s_rdata, data);
      chk("rresp_stall", s_rresp, resp);
      chk("arready_stall", s_arready, 0);
      chk("arvalid_stall", m_arvalid, 0);
    end
    s_arvalid = 0;
    s_rready = 1;
    @(negedge clk);
    s_rready = 0;
    chk("rvalid_done", s_rvalid, 0);
    chk("arready_done", s_arready, 1);
  endtask
  task automatic decerr2(input logic [31:0] addr);
    @(negedge clk);
    chk("arready2_idle", s_arready2, 1);
    s_araddr2 = addr;
    s_arvalid2 = 1;
    @(negedge clk);
    s_arvalid2 = 0;
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
    decerr_n++;
    chk("errcnt2", err_cnt2, decerr_n);
`endif
    chk("rvalid2_t1", s_rvalid2, 1);
    chk("rdata2", s_rdata2, 0);
    chk("rresp2", s_rresp2, 2'b11);
    chk("arvalid2_none", m_arvalid2, 0);
    chk("arready2_busy", s_arready2, 0);
    s_rready2 = 1;
    @(negedge clk);
    s_rready2 = 0;
    chk("rvalid2_done", s_rvalid2, 0);
    chk("arready2_done", s_arready2, 1);
    chk("arvalid2_after", m_arvalid2, 0);
    chk("rready2_after", m_rready2, 0);
  endtask
  initial begin
    logic [31:0] a;
    #1 chk_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    read3(32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    read3(32'h2000_0000, 4, 3, 0, $urandom, 2'b10);
    read3(32'h4000_0100, 1, 1, 5, $urandom, 2'b00);
    read3(32'h0FFF_FFFF, 0, 2, 0, $urandom, 2'b01);
    read3(32'h1000_0000, 2, 0, 1, $urandom, 2'b11);
    read3(32'h3FFF_FFFF, 0, 0, 0, $urandom, 2'b00);
    read3(32'h4000_0000, 0, 0, 0, $urandom, 2'b10);
    read3(32'hFFFF_FFFF, 1, 0, 0, $urandom, 2'b00);
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0: a = $urandom_range(32'h0FFF_FFFF, 0);
        1: a = 32'h1000_0000 + $urandom_range(32'h2FFF_FFFF, 0);
        default: a = 32'h4000_0000 + $urandom_range(32'hBFFF_FFFF, 0);
      endcase
      read3(a, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom, 2'($urandom));
    end
    @(negedge clk);
    s_araddr = 32'h1800_0000;
    s_arvalid = 1;
    @(negedge clk);
    s_arvalid = 0;
    m_arready = 3'b010;
    @(negedge clk);
    m_arready = 0;
    chk("rready_pre_rst", m_rready, 3'b010);
    #2 rst = 1;
    #1 chk_reset();
    @(negedge clk);
    rst = 0;
`ifdef AXI_RD_ROUTER_ERR_CNT_EN
    decerr_n = 0;
`endif
    read3(32'h3000_0000, 0, 0, 0, $urandom, 2'b00);
    decerr2(32'h8000_0000);
    for (int i = 0; i < 4; i++) decerr2(32'h4000_0000 + $urandom_range(32'hBFFF_FFFF, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
